// File: rtl/power_spec_pkg.sv
// power_spec_pkg: shared types and constants for the power_spec_avg slice.
//   state_t    - run-control FSM states
//   PIPE_DEPTH - dv -> spec_valid latency in cycles
//   MULT_LAT   - squaring multiplier latency in cycles (stages 1..3)
package power_spec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

  localparam int unsigned PIPE_DEPTH = 5;
  localparam int unsigned MULT_LAT   = 3;

endpackage

// File: rtl/power_spec_avg_if.sv
// power_spec_avg_if: control, FFT-input and spectrum-output signals of
// power_spec_avg grouped into one bundle.
//   master - driver side (FFT core / controller / spectrum sink)
//   slave  - power_spec_avg side
// Inputs to the block: start, num_frames, dv, xk_index, xk_re, xk_im.
// Outputs of the block: busy, spec_valid, spec_index, spec_data, done, ovf.
interface power_spec_avg_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 10,
  parameter int FRM_W  = 8,
  parameter int ACC_W  = 48
);

  logic                     start;
  logic [FRM_W-1:0]         num_frames;
  logic                     dv;
  logic [IDX_W-1:0]         xk_index;
  logic signed [DATA_W-1:0] xk_re;
  logic signed [DATA_W-1:0] xk_im;
  logic                     busy;
  logic                     spec_valid;
  logic [IDX_W-1:0]         spec_index;
  logic [ACC_W-1:0]         spec_data;
  logic                     done;
  logic                     ovf;

  modport master (
    output start, num_frames, dv, xk_index, xk_re, xk_im,
    input  busy, spec_valid, spec_index, spec_data, done, ovf
  );

  modport slave (
    input  start, num_frames, dv, xk_index, xk_re, xk_im,
    output busy, spec_valid, spec_index, spec_data, done, ovf
  );

endinterface

// File: rtl/spec_acc_ram.sv
// spec_acc_ram: simple dual-port synchronous RAM holding one accumulator
// per FFT bin. One write port, one read port, read latency 1 cycle.
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address (data appears on rdata the next cycle)
//   rdata - registered read data
module spec_acc_ram #(
  parameter int DW = 48,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/power_spec_avg.sv
// power_spec_avg: per-bin |X|^2 of the streaming FFT output, accumulated
// over num_frames consecutive frames; the last frame streams the totals.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - power_spec_avg_if.slave (start/num_frames, dv/xk_*,
//           busy, spec_valid/spec_index/spec_data, done, ovf)
// Parameters must match those of the connected interface.
// Build option: POWER_SPEC_SAT_EN - saturate the accumulator at
// 2**ACC_W-1 instead of wrapping (ovf sets in both cases).
// Pipeline: stages 1..3 square, 4 sums, 5 adds and writes back.
module power_spec_avg
  import power_spec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 10,
  parameter int FRM_W  = 8,
  parameter int ACC_W  = 48
) (
  input logic            clk,
  input logic            rst_n,
  power_spec_avg_if.slave bus
);

  localparam int PW = 2 * DATA_W + 1;
  localparam int unsigned S4 = MULT_LAT;
  localparam int unsigned S5 = PIPE_DEPTH - 1;

  state_t state, state_n;
  logic [FRM_W-1:0] nf, frame_cnt;
  logic synced, accept, start_acc, done_c, ovf_q;
  logic frame_end, first_frm, last_frm;

  logic [PIPE_DEPTH-1:0] v_pipe, first_pipe, last_pipe;
  logic [IDX_W-1:0]      idx_pipe [PIPE_DEPTH];

  logic signed [DATA_W-1:0]   s1_re, s1_im;
  logic signed [2*DATA_W-1:0] sq_re, sq_im;
  logic [2*DATA_W-1:0]        s2_sqr, s2_sqi, s3_sqr, s3_sqi;
  logic [PW-1:0]              s4_p;
  logic [ACC_W-1:0]           s5_data, rd_data, old_val, new_val;
  logic [ACC_W:0]             acc_sum;
  logic                       carry;

  assign frame_end = &bus.xk_index;
  assign first_frm = (frame_cnt == '0);
  assign last_frm  = (frame_cnt == nf - 1'b1);

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    start_acc = 1'b0;
    done_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          start_acc = 1'b1;
          state_n   = ACCUM;
        end
      end
      ACCUM: begin
        // A run only starts on a frame boundary: drop samples until bin 0.
        accept = bus.dv && (synced || bus.xk_index == '0);
        if (accept && frame_end && last_frm) state_n = DRAIN;
      end
      DRAIN: begin
        if (v_pipe == '0) begin
          done_c  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      nf        <= '0;
      frame_cnt <= '0;
      synced    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (start_acc) begin
        nf        <= (bus.num_frames == '0) ? FRM_W'(1) : bus.num_frames;
        frame_cnt <= '0;
        synced    <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        if (accept) begin
          synced <= 1'b1;
          if (frame_end) frame_cnt <= frame_cnt + 1'b1;
        end
        if (v_pipe[S4] && carry) ovf_q <= 1'b1;
      end
    end
  end

  assign sq_re = (2*DATA_W)'(s1_re) * (2*DATA_W)'(s1_re);
  assign sq_im = (2*DATA_W)'(s1_im) * (2*DATA_W)'(s1_im);

  // First frame ignores the RAM, so it never needs clearing.
  always_comb begin
    old_val = first_pipe[S4] ? '0 : rd_data;
    acc_sum = {1'b0, old_val} + {1'b0, ACC_W'(s4_p)};
    carry   = acc_sum[ACC_W];
`ifdef POWER_SPEC_SAT_EN
    new_val = carry ? '1 : acc_sum[ACC_W-1:0];
`else
    new_val = acc_sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe     <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) idx_pipe[i] <= '0;
      s1_re   <= '0;
      s1_im   <= '0;
      s2_sqr  <= '0;
      s2_sqi  <= '0;
      s3_sqr  <= '0;
      s3_sqi  <= '0;
      s4_p    <= '0;
      s5_data <= '0;
    end else begin
      v_pipe     <= {v_pipe[PIPE_DEPTH-2:0], accept};
      first_pipe <= {first_pipe[PIPE_DEPTH-2:0], first_frm};
      last_pipe  <= {last_pipe[PIPE_DEPTH-2:0], last_frm};
      idx_pipe[0] <= bus.xk_index;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) idx_pipe[i] <= idx_pipe[i-1];
      s1_re  <= bus.xk_re;
      s1_im  <= bus.xk_im;
      s2_sqr <= sq_re;
      s2_sqi <= sq_im;
      s3_sqr <= s2_sqr;
      s3_sqi <= s2_sqi;
      s4_p   <= {1'b0, s3_sqr} + {1'b0, s3_sqi};
      if (v_pipe[S4]) s5_data <= new_val;
    end
  end

  // Read issued from stage 3 so the old value lines up with the stage-4 sum;
  // write-back happens from stage 5, the same cycle the result is presented.
  spec_acc_ram #(
    .DW(ACC_W),
    .AW(IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (v_pipe[S5]),
    .waddr(idx_pipe[S5]),
    .wdata(s5_data),
    .raddr(idx_pipe[MULT_LAT-1]),
    .rdata(rd_data)
  );

  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_c;
  assign bus.ovf        = ovf_q;
  assign bus.spec_valid = v_pipe[S5] & last_pipe[S5];
  assign bus.spec_index = idx_pipe[S5];
  assign bus.spec_data  = s5_data;

endmodule
